// File: rtl/wb_crc32_pkg.sv
// wb_crc32_pkg: register offsets, default CRC-32 constants and the byte-step function
package wb_crc32_pkg;
  localparam logic [1:0] CRC_CTRL   = 2'd0;
  localparam logic [1:0] CRC_DATA   = 2'd1;
  localparam logic [1:0] CRC_RESULT = 2'd2;
  localparam logic [31:0] POLY_DEFAULT   = 32'hEDB8_8320;
  localparam logic [31:0] SEED_DEFAULT   = 32'hFFFF_FFFF;
  localparam logic [31:0] XOROUT_DEFAULT = 32'hFFFF_FFFF;
  function automatic logic [31:0] crc8step(logic [31:0] c, logic [31:0] poly);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ poly : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/wb_if.sv
// wb_if: Wishbone pipelined bus bundle with master and slave views
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        stall;
  logic        err;
  modport slave(input cyc, stb, we, sel, adr, dat_i, output dat_o, ack, stall, err);
  modport master(output cyc, stb, we, sel, adr, dat_i, input dat_o, ack, stall, err);
endinterface

// File: rtl/wb_crc32_byte_engine.sv
// crc32_byte_engine: drains one latched word byte-by-byte into the CRC register
module crc32_byte_engine
  import wb_crc32_pkg::*;
#(
  parameter logic [31:0] POLY = POLY_DEFAULT,
  parameter logic [31:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        init,
  input  logic [31:0] data,
  input  logic [3:0]  sel,
  output logic        busy,
  output logic [31:0] crc,
  output logic [31:0] count
);
  logic [31:0] word;
  logic [3:0]  mask;
  logic [1:0]  lane;
  logic [3:0]  mask_next;
  logic [7:0]  byte_cur;
  // lane points at the lowest still-pending lane, so disabled lanes cost no cycles
  always_comb begin
    lane      = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    mask_next = mask & (mask - 4'd1);
    byte_cur  = word[{lane, 3'b000} +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      crc   <= SEED;
      count <= '0;
      word  <= '0;
      mask  <= '0;
      busy  <= 1'b0;
    end else if (init) begin
      crc   <= SEED;
      count <= '0;
    end else if (load) begin
      word <= data;
      mask <= sel;
      busy <= |sel;
    end else if (busy) begin
      crc   <= crc8step(crc ^ {24'd0, byte_cur}, POLY);
      count <= count + 32'd1;
      mask  <= mask_next;
      busy  <= |mask_next;
    end
  end
endmodule

// File: rtl/wb_crc32.sv
// wb_crc32: Wishbone pipelined slave exposing a byte-serial CRC-32 engine
module wb_crc32
  import wb_crc32_pkg::*;
#(
  parameter logic [31:0] POLY   = POLY_DEFAULT,
  parameter logic [31:0] SEED   = SEED_DEFAULT,
  parameter logic [31:0] XOROUT = XOROUT_DEFAULT
) (
  input logic clk,
  input logic rst,
  wb_if.slave wb
);
  logic        busy;
  logic        accept;
  logic [1:0]  reg_sel;
  logic [31:0] crc;
  logic [31:0] count;
  logic [31:0] rdata;
  assign reg_sel  = wb.adr[3:2];
  assign wb.stall = busy;
  assign wb.err   = 1'b0;
  assign accept   = wb.cyc & wb.stb & ~busy;
  assign rdata    = reg_sel == CRC_CTRL   ? count :
                    reg_sel == CRC_RESULT ? crc ^ XOROUT : 32'd0;
  crc32_byte_engine #(.POLY(POLY), .SEED(SEED)) u_engine (
    .clk  (clk),
    .rst  (rst),
    .load (accept & wb.we & (reg_sel == CRC_DATA)),
    .init (accept & wb.we & (reg_sel == CRC_CTRL)),
    .data (wb.dat_i),
    .sel  (wb.sel),
    .busy (busy),
    .crc  (crc),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wb.ack   <= 1'b0;
      wb.dat_o <= '0;
    end else begin
      wb.ack   <= accept;
      wb.dat_o <= (accept & ~wb.we) ? rdata : 32'd0;
    end
  end
endmodule

// File: doc/wb_crc32.md
# wb_crc32

Wishbone pipelined slave that computes CRC-32 (IEEE 802.3, reflected) over bytes written by the Ibex data master. It sits on the shared-bus interconnect next to the RAM slave and gives the `crc_32` software test a hardware reference result. Internally it is a byte-serial engine: one byte per clock, with stall back-pressure while a written word drains.

## Interface
Parameters:
- `POLY`, `32'hEDB8_8320`: reflected generator polynomial.
- `SEED`, `32'hFFFF_FFFF`: CRC register value after reset or INIT.
- `XOROUT`, `32'hFFFF_FFFF`: XOR applied on RESULT read.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `wb`  slave modport of `wb_if`  —  Wishbone pipelined slave:
  - `cyc`, `stb`, `we`: request qualifiers.
  - `sel[3:0]`: byte lanes.
  - `adr[31:0]`: only `adr[3:2]` is decoded.
  - `dat_i[31:0]` / `dat_o[31:0]`: write / read data.
  - `ack`, `stall` out.
  - `err` out, tied 0.

## Operation
- Register map (word offsets):
  - 0x0 CTRL: write with any `sel` reloads CRC to `SEED` and clears COUNT; read returns COUNT (32-bit bytes-processed counter, wraps at 2^32).
  - 0x4 DATA: write queues the enabled lanes of `dat_i`; read returns 0.
  - 0x8 RESULT: read returns `crc ^ XOROUT`; write ignored.
  - 0xC: reserved; reads 0, writes ignored.
- A request is accepted when `cyc & stb & ~stall`.
- DATA write:
  - Latch `dat_i` and `sel`; the engine becomes busy.
  - Lanes are processed in ascending order (lane 0 = bits 7:0 first); lanes with `sel` = 0 are skipped.
  - Per processed byte: `crc = crc8step(crc ^ byte)`, i.e. 8 LSB-first shift/conditional-XOR-`POLY` iterations, unrolled combinationally; COUNT increments by 1.
  - `sel` = 4'b0000: acked, no busy cycles, CRC unchanged.
- While busy, `stall` = 1 for all requests regardless of address, so CTRL, DATA and RESULT can never race the engine.
- Dropping `cyc` mid-drain does not abort the engine.
- Reset wins over everything; reset during a drain discards the remaining bytes.

## Timing
- Reset values: `ack` = 0, `stall` = 0, `dat_o` = 0, `err` = 0, crc = `SEED`, COUNT = 0, busy = 0.
- `ack` is registered: asserted exactly one cycle after acceptance, for one cycle. `dat_o` is valid in the same cycle as `ack`.
- DATA write with n enabled lanes (n = 1..4):
  - Bytes are processed in cycles 1..n after acceptance.
  - `stall` is high in those same cycles (combinational from busy).
  - A back-to-back request can be accepted in cycle n+1.
  - Peak throughput: 4 bytes per 5 cycles.
- CTRL, RESULT and reserved accesses, and DATA with `sel` = 0: never stall and accept back-to-back every cycle.
- A RESULT read accepted in cycle n+1 reflects all n bytes.

## Structure
- Package `wb_crc32_pkg`:
  - Register offset constants `CRC_CTRL`, `CRC_DATA`, `CRC_RESULT`.
  - Default `POLY`, `SEED`, `XOROUT` constants.
  - Function `crc8step(logic [31:0] c, logic [31:0] poly)`.
- Sub-module `crc32_byte_engine` holds:
  - crc register, COUNT, latched word/`sel`, lane pointer (2-bit) and busy flag.
  - Inputs: load, init, data, sel.
  - Outputs: busy, crc, count.
- Top level holds the bus decode, the ack register and read muxing.

## Test plan
- Reset, then read RESULT → `dat_o` = 32'h0000_0000 (`SEED ^ XOROUT`); read CTRL → 0; `ack` one cycle after acceptance.
- Write CTRL, then DATA 32'h3433_3231 `sel` 1111, DATA 32'h3837_3635 `sel` 1111, DATA 32'h0000_0039 `sel` 0001 ("123456789") → RESULT = 32'hCBF4_3926, COUNT = 9; `stall` high exactly 4, 4, 1 cycles.
- Write CTRL, then DATA 32'h0000_6100 `sel` 0010 → RESULT = 32'hE8B7_BE43 ("a"); `stall` high 1 cycle.
- Back-to-back DATA writes held on the bus → second is accepted only in cycle 5 after the first; no byte is lost or duplicated.
- Assert `rst` in cycle 2 of a 4-lane drain → the following cycle shows `stall` = 0, RESULT = 0, COUNT = 0; a subsequent "123456789" sequence still yields 32'hCBF4_3926.
- DATA with `sel` 0000, and read/write to 0xC → `ack` after one cycle, no stall, `dat_o` = 0, CRC unchanged.
